// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter
//   Shares one external 256x8 S-box ROM between the round SubBytes datapath
//   (requester 0) and the key-expansion SubWord path (requester 1). An
//   accepted 32-bit word is substituted one byte at a time, MSB byte first.
//   The substituted word goes back to the granted requester with a
//   single-cycle response pulse.
//
//   Build option: define AES_SBOX_ARB_KEYPRIO_EN to give requester 1 fixed
//   priority when both requesters are valid. Without it, simultaneous
//   requests are served round robin.
//
// Parameters
//   ROM_WAIT     extra wait cycles per ROM read beyond the first (0..7)
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0_valid/word/ready      requester 0 handshake (ready is combinational)
//   rsp0_valid/word            requester 0 response pulse and held result
//   req1_valid/word/ready      requester 1 handshake (ready is combinational)
//   rsp1_valid/word            requester 1 response pulse and held result
//   rom_addr, rom_data         ROM address out, ROM data in
//   rom_ce_n, rom_oe_n         ROM chip/output enables, active low
//   busy                       high whenever a lookup sequence is running
module aes_sbox_arbiter #(
  parameter int ROM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_word,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_word,
  input  logic        req1_valid,
  input  logic [31:0] req1_word,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_word,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        rom_ce_n,
  output logic        rom_oe_n,
  output logic        busy
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(ROM_WAIT);

  state_t      state, state_next;
  logic        grant_id;
  logic        accept;
  logic        capture;
  logic        gid_q;
  logic [1:0]  idx;
  logic [2:0]  wait_cnt;
  logic [31:0] word_q;
  // Only the first three result bytes are stored; the last byte goes
  // straight from rom_data into the response register.
  logic [23:0] result_q;
`ifndef AES_SBOX_ARB_KEYPRIO_EN
  logic        last_grant;
`endif

  // Byte i of a word, counting from the MSB byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    b = w[31:24];
    case (i)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
    endcase
    return b;
  endfunction

  always_comb begin
    grant_id   = 1'b0;
    state_next = state;
`ifdef AES_SBOX_ARB_KEYPRIO_EN
    grant_id = req1_valid;
`else
    // A lone requester wins outright; a tie goes to whoever did not win last.
    grant_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
`endif
    req0_ready = (state == IDLE) && !grant_id && req0_valid;
    req1_ready = (state == IDLE) &&  grant_id && req1_valid;
    accept     = req0_ready || req1_ready;
    capture    = (state == READ) && (wait_cnt == 3'd0);
    case (state)
      IDLE: if (accept) state_next = READ;
      READ: if (capture && idx == 2'd3) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Control and ROM pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= 8'h00;
      rom_ce_n   <= 1'b1;
      rom_oe_n   <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_word  <= 32'h0;
      rsp1_word  <= 32'h0;
      idx        <= 2'd0;
      wait_cnt   <= 3'd0;
      gid_q      <= 1'b0;
`ifndef AES_SBOX_ARB_KEYPRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            gid_q    <= grant_id;
`ifndef AES_SBOX_ARB_KEYPRIO_EN
            last_grant <= grant_id;
`endif
            rom_addr <= grant_id ? req1_word[31:24] : req0_word[31:24];
            rom_ce_n <= 1'b0;
            rom_oe_n <= 1'b0;
            idx      <= 2'd0;
            wait_cnt <= WAIT_INIT;
          end
        end
        READ: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else if (idx != 2'd3) begin
            idx      <= idx + 2'd1;
            rom_addr <= byte_sel(word_q, idx + 2'd1);
            wait_cnt <= WAIT_INIT;
          end else begin
            rom_ce_n <= 1'b1;
            rom_oe_n <= 1'b1;
            if (gid_q) begin
              rsp1_valid <= 1'b1;
              rsp1_word  <= {result_q, rom_data};
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_word  <= {result_q, rom_data};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data registers: accepted word and partial result
  always_ff @(posedge clk) begin
    if (accept) word_q <= grant_id ? req1_word : req0_word;
    if (capture) begin
      case (idx)
        2'd0: result_q[23:16] <= rom_data;
        2'd1: result_q[15:8]  <= rom_data;
        2'd2: result_q[7:0]   <= rom_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Self-checking bench for aes_sbox_arbiter. Two instances are built:
// index 0 with ROM_WAIT=0, index 1 with ROM_WAIT=2. Each has a ROM model
// that only returns the S-box value once the address has been stable and
// enabled for the required number of cycles, and returns junk otherwise.
module tb_aes_sbox_arbiter;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef struct {
    int          d;
    int          id;
    logic [31:0] word;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid [2];
  logic        req1_valid [2];
  logic [31:0] req0_word  [2];
  logic [31:0] req1_word  [2];
  logic        req0_ready [2];
  logic        req1_ready [2];
  logic        rsp0_valid [2];
  logic        rsp1_valid [2];
  logic [31:0] rsp0_word  [2];
  logic [31:0] rsp1_word  [2];
  logic [7:0]  rom_addr   [2];
  logic [7:0]  rom_data   [2];
  logic        rom_ce_n   [2];
  logic        rom_oe_n   [2];
  logic        busy       [2];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : 2;
    logic [7:0] seen_addr;
    int         age = 0;

    aes_sbox_arbiter #(.ROM_WAIT(W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid[g]),
      .req0_word  (req0_word[g]),
      .req0_ready (req0_ready[g]),
      .rsp0_valid (rsp0_valid[g]),
      .rsp0_word  (rsp0_word[g]),
      .req1_valid (req1_valid[g]),
      .req1_word  (req1_word[g]),
      .req1_ready (req1_ready[g]),
      .rsp1_valid (rsp1_valid[g]),
      .rsp1_word  (rsp1_word[g]),
      .rom_addr   (rom_addr[g]),
      .rom_data   (rom_data[g]),
      .rom_ce_n   (rom_ce_n[g]),
      .rom_oe_n   (rom_oe_n[g]),
      .busy       (busy[g])
    );

    // Age of the current address, counted in falling edges since it changed.
    always @(negedge clk) begin
      if (rom_addr[g] !== seen_addr) begin
        seen_addr = rom_addr[g];
        age = 0;
      end else if (age < 100) begin
        age++;
      end
    end

    assign rom_data[g] = (!rom_ce_n[g] && !rom_oe_n[g] && rom_addr[g] === seen_addr && age >= W)
                         ? SBOX[rom_addr[g]] : 8'hA5;
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic exp_t mk(input int d, input int id, input logic [31:0] w, input int due);
    exp_t e;
    e.d = d; e.id = id; e.word = w; e.due = due;
    return e;
  endfunction

  // Scoreboard: every response pulse pops the oldest expectation.
  exp_t        mon_e;
  logic        mon_v;
  logic [31:0] mon_w;
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        mon_v = (r == 0) ? rsp0_valid[d] : rsp1_valid[d];
        mon_w = (r == 0) ? rsp0_word[d] : rsp1_word[d];
        if (mon_v === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rsp_unexpected dut%0d id%0d word=%h cyc=%0d, required no response", d, r, mon_w, cyc);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.d != d || mon_e.id != r || mon_e.word !== mon_w || mon_e.due != cyc) begin
              n_bad++;
              $display("FAIL rsp dut%0d id%0d word=%h cyc=%0d, required dut%0d id%0d word=%h cyc=%0d",
                       d, r, mon_w, cyc, mon_e.d, mon_e.id, mon_e.word, mon_e.due);
            end
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      req0_valid[d] = 1'b0; req1_valid[d] = 1'b0;
      req0_word[d] = 32'h0; req1_word[d] = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy[0] || busy[1]) && n < max) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= max) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout pending=%0d, required 0 within %0d cycles", exp_q.size(), max);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rom_addr[d] !== 8'h00) begin n_bad++; $display("FAIL reset_rom_addr dut%0d got %h required 00", d, rom_addr[d]); end
      n_cmp++;
      if (rom_ce_n[d] !== 1'b1 || rom_oe_n[d] !== 1'b1) begin
        n_bad++; $display("FAIL reset_rom_en dut%0d got ce_n=%b oe_n=%b required 1/1", d, rom_ce_n[d], rom_oe_n[d]);
      end
      n_cmp++;
      if (rsp0_valid[d] !== 1'b0 || rsp1_valid[d] !== 1'b0) begin
        n_bad++; $display("FAIL reset_rsp_valid dut%0d got %b%b required 00", d, rsp0_valid[d], rsp1_valid[d]);
      end
      n_cmp++;
      if (rsp0_word[d] !== 32'h0 || rsp1_word[d] !== 32'h0) begin
        n_bad++; $display("FAIL reset_rsp_word dut%0d got %h/%h required 0/0", d, rsp0_word[d], rsp1_word[d]);
      end
      n_cmp++;
      if (busy[d] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d got %b required 0", d, busy[d]); end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp_a [4];
    exp_a[0] = 8'h00; exp_a[1] = 8'h01; exp_a[2] = 8'h53; exp_a[3] = 8'hFF;
    @(posedge clk); #1;
    req0_word[0] = 32'h000153FF; req0_valid[0] = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready[0] !== 1'b1 || req1_ready[0] !== 1'b0) begin
      n_bad++; $display("FAIL single_ready got r0=%b r1=%b required 1/0", req0_ready[0], req1_ready[0]);
    end
    exp_q.push_back(mk(0, 0, 32'h637CED16, cyc + 1 + 4));
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rom_addr[0] !== exp_a[k] || rom_ce_n[0] !== 1'b0 || rom_oe_n[0] !== 1'b0 || busy[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL single_addr k=%0d got addr=%h ce_n=%b oe_n=%b busy=%b required addr=%h 0/0/1",
                 k, rom_addr[0], rom_ce_n[0], rom_oe_n[0], busy[0], exp_a[k]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (rom_ce_n[0] !== 1'b1 || rom_oe_n[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL single_done got ce_n=%b oe_n=%b busy=%b required 1/1/0", rom_ce_n[0], rom_oe_n[0], busy[0]);
    end
    n_cmp++;
    if (rom_addr[0] !== 8'hFF) begin n_bad++; $display("FAIL idle_addr_hold got %h required ff", rom_addr[0]); end
    wait_drain(20);
  endtask

  // Drives both requesters and records grant order and accept cycles.
  // When hold is set, the winner keeps requesting with a fresh word.
  task automatic run_pair(input int n_acc, input bit hold, output int order[$], output int acc[$]);
    bit drop0, drop1;
    drop0 = 1'b0; drop1 = 1'b0;
    for (int t = 0; t < 80 && order.size() < n_acc; t++) begin
      #1;
      n_cmp++;
      if (req0_ready[0] === 1'b1 && req1_ready[0] === 1'b1) begin
        n_bad++; $display("FAIL both_ready cyc=%0d got 1/1 required at most one", cyc);
      end
      if (req0_ready[0] === 1'b1) begin
        exp_q.push_back(mk(0, 0, sub_word(req0_word[0]), cyc + 5));
        order.push_back(0); acc.push_back(cyc + 1); drop0 = 1'b1;
      end
      if (req1_ready[0] === 1'b1) begin
        exp_q.push_back(mk(0, 1, sub_word(req1_word[0]), cyc + 5));
        order.push_back(1); acc.push_back(cyc + 1); drop1 = 1'b1;
      end
      @(posedge clk); #1;
      if (order.size() >= n_acc) begin
        req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;
      end
      if (drop0) begin
        if (hold) req0_word[0] = $urandom(); else req0_valid[0] = 1'b0;
        drop0 = 1'b0;
      end
      if (drop1) begin
        if (hold) req1_word[0] = $urandom(); else req1_valid[0] = 1'b0;
        drop1 = 1'b0;
      end
    end
    req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;
  endtask

  task automatic test_rr_pair();
    int order[$];
    int acc[$];
    int first;
    do_reset();
    req0_word[0] = 32'h00000000; req1_word[0] = 32'h01010101;
    req0_valid[0] = 1'b1; req1_valid[0] = 1'b1;
    run_pair(2, 1'b0, order, acc);
`ifdef AES_SBOX_ARB_KEYPRIO_EN
    first = 1;
`else
    first = 0;
`endif
    n_cmp++;
    if (order.size() != 2) begin
      n_bad++; $display("FAIL pair_count got %0d required 2", order.size());
    end else begin
      n_cmp++;
      if (order[0] != first || order[1] != 1 - first) begin
        n_bad++; $display("FAIL pair_order got %0d,%0d required %0d,%0d", order[0], order[1], first, 1 - first);
      end
      n_cmp++;
      if (acc[1] - acc[0] != 5) begin
        n_bad++; $display("FAIL pair_gap got %0d required 5", acc[1] - acc[0]);
      end
    end
    // Pin the test-plan constants independently of the model lookups.
    n_cmp++;
    if (sub_word(32'h01010101) !== 32'h7C7C7C7C || sub_word(req0_word[0]) !== 32'h63636363) begin
      n_bad++; $display("FAIL pair_model got %h required 7c7c7c7c", sub_word(32'h01010101));
    end
    wait_drain(20);
    n_cmp++;
    if (rsp0_word[0] !== 32'h63636363 || rsp1_word[0] !== 32'h7C7C7C7C) begin
      n_bad++; $display("FAIL pair_words got %h/%h required 63636363/7c7c7c7c", rsp0_word[0], rsp1_word[0]);
    end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int acc[$];
    int exp_g [4];
`ifdef AES_SBOX_ARB_KEYPRIO_EN
    exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1;
`else
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`endif
    do_reset();
    req0_word[0] = $urandom(); req1_word[0] = $urandom();
    req0_valid[0] = 1'b1; req1_valid[0] = 1'b1;
    run_pair(4, 1'b1, order, acc);
    n_cmp++;
    if (order.size() != 4) begin
      n_bad++; $display("FAIL b2b_count got %0d required 4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (order[k] != exp_g[k]) begin
          n_bad++; $display("FAIL b2b_grant k=%0d got %0d required %0d", k, order[k], exp_g[k]);
        end
      end
      for (int k = 1; k < 4; k++) begin
        n_cmp++;
        if (acc[k] - acc[k-1] != 5) begin
          n_bad++; $display("FAIL b2b_gap k=%0d got %0d required 5", k, acc[k] - acc[k-1]);
        end
      end
    end
    wait_drain(20);
  endtask

  task automatic wait2_xact(input logic [31:0] w);
    logic [7:0] exp_addr;
    #1;
    req1_word[1] = w; req1_valid[1] = 1'b1;
    #1;
    n_cmp++;
    if (req1_ready[1] !== 1'b1 || req0_ready[1] !== 1'b0) begin
      n_bad++; $display("FAIL wait2_ready got r0=%b r1=%b required 0/1", req0_ready[1], req1_ready[1]);
    end
    exp_q.push_back(mk(1, 1, sub_word(w), cyc + 1 + 12));
    @(posedge clk); #1;
    req1_valid[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      exp_addr = (k < 3) ? w[31:24] : (k < 6) ? w[23:16] : (k < 9) ? w[15:8] : w[7:0];
      n_cmp++;
      if (rom_addr[1] !== exp_addr || rom_ce_n[1] !== 1'b0 || busy[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL wait2_addr k=%0d got addr=%h ce_n=%b busy=%b required addr=%h 0/1",
                 k, rom_addr[1], rom_ce_n[1], busy[1], exp_addr);
      end
      @(posedge clk); #1;
    end
    wait_drain(30);
  endtask

  task automatic test_rom_wait();
    wait2_xact(32'h53535353);
    n_cmp++;
    if (rsp1_word[1] !== 32'hEDEDEDED) begin
      n_bad++; $display("FAIL wait2_word got %h required edededed", rsp1_word[1]);
    end
    wait2_xact(32'h1F2E3D4C);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req0_word[0] = 32'hA1B2C3D4; req0_valid[0] = 1'b1;
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rom_addr[0] !== 8'hC3 || busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL abort_setup got addr=%h busy=%b required c3/1", rom_addr[0], busy[0]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rom_ce_n[0] !== 1'b1 || rom_oe_n[0] !== 1'b1 || busy[0] !== 1'b0 || rsp0_word[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_state got ce_n=%b oe_n=%b busy=%b word=%h required 1/1/0/0",
               rom_ce_n[0], rom_oe_n[0], busy[0], rsp0_word[0]);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      n_cmp++;
      if (rsp0_valid[0] !== 1'b0 || rsp1_valid[0] !== 1'b0) begin
        n_bad++; $display("FAIL abort_rsp k=%0d got %b%b required 00", k, rsp0_valid[0], rsp1_valid[0]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req0_word[0] = 32'hFFFFFFFF; req0_valid[0] = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready[0] !== 1'b1) begin
      n_bad++; $display("FAIL abort_reaccept got %b required 1", req0_ready[0]);
    end
    exp_q.push_back(mk(0, 0, 32'h16161616, cyc + 5));
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_change_during_read();
    logic [31:0] w;
    w = 32'h3C5A7E90;
    @(posedge clk); #1;
    req0_word[0] = w; req0_valid[0] = 1'b1;
    #1;
    exp_q.push_back(mk(0, 0, sub_word(w), cyc + 5));
    @(posedge clk); #1;
    req0_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req0_word[0] = $urandom();
      req1_word[0] = $urandom();
      req1_valid[0] = (k < 3);
      #1;
      n_cmp++;
      if (busy[0] !== 1'b1 || req1_ready[0] !== 1'b0 || req0_ready[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL read_ignore k=%0d got busy=%b r0=%b r1=%b required 1/0/0",
                 k, busy[0], req0_ready[0], req1_ready[0]);
      end
      @(posedge clk); #1;
    end
    wait_drain(20);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rsp0_word[0] !== sub_word(w)) begin
      n_bad++; $display("FAIL rsp_hold got %h required %h", rsp0_word[0], sub_word(w));
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_rr_pair();
    test_back_to_back();
    test_rom_wait();
    test_reset_mid();
    test_change_during_read();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL leftover_expect got %0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

endmodule
